// File: rtl/exec_ctrl_pkg.sv
// exec_ctrl_pkg: shared types and encodings for the EX-stage control unit.
// Operation codes, ALUOp values, Funct7 constants and FSM states.
package exec_ctrl_pkg;

    typedef enum logic [4:0] {
        OP_AND    = 5'd0,
        OP_OR     = 5'd1,
        OP_ADD    = 5'd2,
        OP_XOR    = 5'd3,
        OP_SLL    = 5'd4,
        OP_SRL    = 5'd5,
        OP_SRA    = 5'd6,
        OP_SUB    = 5'd7,
        OP_SLT    = 5'd8,
        OP_SLTU   = 5'd9,
        OP_MUL    = 5'd16,
        OP_MULH   = 5'd17,
        OP_MULHSU = 5'd18,
        OP_MULHU  = 5'd19,
        OP_DIV    = 5'd20,
        OP_DIVU   = 5'd21,
        OP_REM    = 5'd22,
        OP_REMU   = 5'd23
    } op_e;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_RI  = 2'b10;
    localparam logic [1:0] ALUOP_JMP = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    // RV32M ops map onto 16 + funct3
    function automatic op_e mdu_op(input logic [2:0] f3);
        return op_e'({2'b10, f3});
    endfunction

endpackage

// File: rtl/exec_ctrl_unit_decode.sv
// exec_ctrl_decode: combinational ALUOp/Funct7/Funct3 decode.
// Define EXEC_CTRL_DIV_EN to decode the RV32M divide group.
module exec_ctrl_decode
    import exec_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic       is_imm,
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    output logic [4:0] operation,
    output logic       is_mdu,
    output logic       is_div,
    output logic       illegal
);

    logic f7_base;
    logic f7_alt;
    logic r_ok;
    op_e  op;

    assign f7_base   = (funct7 == F7_BASE);
    assign f7_alt    = (funct7 == F7_ALT);
    assign r_ok      = is_imm | f7_base;
    assign operation = op;

    always_comb begin
        op      = OP_ADD;
        is_mdu  = 1'b0;
        is_div  = 1'b0;
        illegal = 1'b0;
        unique case (alu_op)
            ALUOP_BR: begin
                unique case (funct3)
                    3'b000, 3'b001: op = OP_SUB;
                    3'b100, 3'b101: op = OP_SLT;
                    3'b110, 3'b111: op = OP_SLTU;
                    default:        illegal = 1'b1;
                endcase
            end
            ALUOP_RI: begin
                if (!is_imm && funct7 == F7_MULDIV) begin
`ifdef EXEC_CTRL_DIV_EN
                    op     = mdu_op(funct3);
                    is_mdu = 1'b1;
                    is_div = funct3[2];
`else
                    if (funct3[2]) begin
                        illegal = 1'b1;
                    end else begin
                        op     = mdu_op(funct3);
                        is_mdu = 1'b1;
                    end
`endif
                end else begin
                    // shifts check funct7 even for I-type
                    unique case (funct3)
                        3'b000: begin
                            if (!is_imm && f7_alt) op = OP_SUB;
                            else if (r_ok)         op = OP_ADD;
                            else                   illegal = 1'b1;
                        end
                        3'b001: begin
                            if (f7_base) op = OP_SLL;
                            else         illegal = 1'b1;
                        end
                        3'b010: begin
                            if (r_ok) op = OP_SLT;
                            else      illegal = 1'b1;
                        end
                        3'b011: begin
                            if (r_ok) op = OP_SLTU;
                            else      illegal = 1'b1;
                        end
                        3'b100: begin
                            if (r_ok) op = OP_XOR;
                            else      illegal = 1'b1;
                        end
                        3'b101: begin
                            if (f7_base)     op = OP_SRL;
                            else if (f7_alt) op = OP_SRA;
                            else             illegal = 1'b1;
                        end
                        3'b110: begin
                            if (r_ok) op = OP_OR;
                            else      illegal = 1'b1;
                        end
                        default: begin
                            if (r_ok) op = OP_AND;
                            else      illegal = 1'b1;
                        end
                    endcase
                end
            end
            default: op = OP_ADD;
        endcase
    end

endmodule

// File: rtl/exec_ctrl_unit.sv
// exec_ctrl_unit: registered EX-stage op decode and MDU sequencer.
// Define EXEC_CTRL_DIV_EN to sequence DIV/DIVU/REM/REMU with DIV_LAT.
module exec_ctrl_unit
    import exec_ctrl_pkg::*;
#(
    parameter int OP_W    = 5,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 33
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic            is_imm,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic            flush,
    input  logic            stall_in,
    output logic            out_valid,
    output logic [OP_W-1:0] operation,
    output logic            is_mdu,
    output logic            mdu_start,
    output logic            mdu_kill,
    output logic            busy,
    output logic            illegal
);

`ifdef EXEC_CTRL_DIV_EN
    localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
`else
    localparam int MAX_LAT = MUL_LAT;
`endif
    localparam int CW = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] MUL_LD  = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam bit MUL_ONE = (MUL_LAT == 1);
`ifdef EXEC_CTRL_DIV_EN
    localparam logic [CW-1:0] DIV_LD = CW'(DIV_LAT - 1);
`endif

    if (OP_W < 5 || MUL_LAT < 1 || DIV_LAT < 2) begin : g_param_chk
        $error("exec_ctrl_unit: OP_W>=5, MUL_LAT>=1, DIV_LAT>=2");
    end

    state_e          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt, cnt_ld;
    logic [4:0]      dec_op;
    logic            dec_mdu, dec_div, dec_ill;
    logic            accept, lat_one;
    logic            valid_nxt, mdu_nxt, ill_nxt;
    logic            start_nxt, kill_nxt;
    logic [OP_W-1:0] op_nxt;

    exec_ctrl_decode u_decode (
        .alu_op    (alu_op),
        .is_imm    (is_imm),
        .funct7    (funct7),
        .funct3    (funct3),
        .operation (dec_op),
        .is_mdu    (dec_mdu),
        .is_div    (dec_div),
        .illegal   (dec_ill)
    );

    assign in_ready = (state == IDLE) & ~stall_in & ~flush & ~reset;
    assign accept   = in_valid & in_ready;
    assign busy     = (state != IDLE);
    assign lat_one  = ~dec_div & MUL_ONE;

`ifdef EXEC_CTRL_DIV_EN
    assign cnt_ld = dec_div ? DIV_LD : MUL_LD;
`else
    assign cnt_ld = MUL_LD;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        valid_nxt = out_valid;
        op_nxt    = operation;
        mdu_nxt   = is_mdu;
        ill_nxt   = illegal;
        start_nxt = 1'b0;
        kill_nxt  = 1'b0;
        if (flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            valid_nxt = 1'b0;
            mdu_nxt   = 1'b0;
            ill_nxt   = 1'b0;
            kill_nxt  = (state != IDLE);
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_nxt    = OP_W'(dec_op);
                        ill_nxt   = dec_ill;
                        mdu_nxt   = 1'b0;
                        valid_nxt = 1'b1;
                        if (dec_mdu) begin
                            start_nxt = 1'b1;
                            if (lat_one) begin
                                state_nxt = DONE;
                                mdu_nxt   = 1'b1;
                                cnt_nxt   = '0;
                            end else begin
                                state_nxt = BUSY;
                                valid_nxt = 1'b0;
                                cnt_nxt   = cnt_ld;
                            end
                        end
                    end else if (!stall_in) begin
                        valid_nxt = 1'b0;
                        mdu_nxt   = 1'b0;
                        ill_nxt   = 1'b0;
                    end
                end
                BUSY: begin
                    // countdown ignores stall; DONE absorbs the hold
                    cnt_nxt = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state_nxt = DONE;
                        valid_nxt = 1'b1;
                        mdu_nxt   = 1'b1;
                    end
                end
                DONE: begin
                    if (!stall_in) begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                        mdu_nxt   = 1'b0;
                        ill_nxt   = 1'b0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    valid_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            operation <= OP_W'(OP_ADD);
            is_mdu    <= 1'b0;
            illegal   <= 1'b0;
            mdu_start <= 1'b0;
            mdu_kill  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            out_valid <= valid_nxt;
            operation <= op_nxt;
            is_mdu    <= mdu_nxt;
            illegal   <= ill_nxt;
            mdu_start <= start_nxt;
            mdu_kill  <= kill_nxt;
        end
    end

endmodule

// File: doc/exec_ctrl_unit.md
Name: exec_ctrl_unit

Overview:
Registered, parametrised successor to the combinational ALU-operation decoder in the EX stage.
- Decodes ALUOp/Funct7/Funct3 into an OP_W-bit operation code, and adds RV32M multiply/divide decode.
- Sequences multi-cycle MDU operations through an FSM, with a valid/ready handshake toward ID and a hold input from MEM.
- Sits between the ID/EX register and the ALU/MDU datapath.

Parameters:
OP_W, 5, operation code width; must be ≥5
MUL_LAT, 2, cycles from accept to out_valid for MUL/MULH/MULHSU/MULHU (≥1)
DIV_LAT, 33, cycles from accept to out_valid for DIV/DIVU/REM/REMU (≥2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
in_valid  in  1  ID/EX holds a valid instruction
in_ready  out  1  block can accept this cycle
alu_op  in  2  00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/LUI
is_imm  in  1  I-type arithmetic (Funct7 ignored except shifts)
funct7  in  7  instr[31:25]
funct3  in  3  instr[14:12]
flush  in  1  kill in-flight operation
stall_in  in  1  downstream hold
out_valid  out  1  operation valid to ALU/MDU mux
operation  out  OP_W  decoded operation code
is_mdu  out  1  result comes from MDU
mdu_start  out  1  one-cycle MDU launch pulse
mdu_kill  out  1  one-cycle MDU abort pulse
busy  out  1  FSM not IDLE
illegal  out  1  unsupported encoding; qualified by out_valid

Behaviour:
- Reset: all outputs 0, operation = OP_ADD, FSM = IDLE, counter = 0. Asynchronous assert; synchronous deassert handled by the system reset synchroniser.
- in_ready = (state==IDLE) & ~stall_in & ~flush. Accept = in_valid & in_ready.
- Decode mapping:
  - alu_op 00 or 11 → OP_ADD.
  - alu_op 01: funct3 000/001 → OP_SUB (branch compare via zero flag); 100/101 → OP_SLT; 110/111 → OP_SLTU; other → illegal.
  - alu_op 10, funct7==0000001 and ~is_imm → MDU op.
  - alu_op 10 otherwise: standard RV32I R/I table. SUB only when ~is_imm & funct7==0100000. SRA when funct7==0100000. Any other funct7 on R-type or shift → illegal, operation = OP_ADD.
- ALU op: registered; out_valid=1 on the cycle after accept (latency 1); FSM stays IDLE.
- MDU op, FSM IDLE→BUSY on accept:
  - mdu_start pulses the cycle after accept.
  - Counter loads LAT-1 and decrements each cycle while BUSY.
  - At counter==0: out_valid=1, is_mdu=1, FSM→DONE.
  - Result: out_valid exactly LAT cycles after accept.
- DONE: holds out_valid while stall_in; returns to IDLE on the first cycle with ~stall_in. out_valid then drops unless a new accept occurs that cycle; accept is not allowed in DONE because in_ready=0.
- stall_in with an ALU op: operation/out_valid hold their values. The BUSY countdown continues during stall_in; completion waits in DONE.
- flush:
  - Next edge: out_valid=0, FSM→IDLE, counter=0.
  - mdu_kill pulses if the FSM was BUSY or DONE.
  - flush with in_valid in the same cycle: input dropped (in_ready=0).
  - flush coincident with counter==0: flush wins, no out_valid.
- illegal: registered alongside out_valid. Illegal encodings never start the MDU.
- busy = (state != IDLE).

Optional Feature:
EXEC_CTRL_DIV_EN
- Defined: DIV/DIVU/REM/REMU decoded as MDU ops with DIV_LAT.
- Undefined: funct7==0000001 with funct3[2]==1 → illegal, latency 1, no mdu_start. MUL group unchanged. Counter width reduces to $clog2(MUL_LAT+1).

Decomposition:
- Package exec_ctrl_pkg:
  - Operation enum with fixed codes: OP_AND=0, OP_OR=1, OP_ADD=2, OP_XOR=3, OP_SLL=4, OP_SRL=5, OP_SRA=6, OP_SUB=7, OP_SLT=8, OP_SLTU=9, OP_MUL=16, OP_MULH=17, OP_MULHSU=18, OP_MULHU=19, OP_DIV=20, OP_DIVU=21, OP_REM=22, OP_REMU=23.
  - ALUOp localparams.
  - FSM state enum {IDLE, BUSY, DONE}.
  - Funct7 constants.
- Sub-module exec_ctrl_decode: pure combinational decode (alu_op, is_imm, funct7, funct3 → operation, is_mdu, illegal). The top holds the registers, FSM and counter.

Test Plan:
- alu_op=10, funct7=0100000, funct3=000, is_imm=0, accept at cycle 0 → cycle 1: out_valid=1, operation=7 (SUB), illegal=0; same encoding with is_imm=1 → operation=2 (ADD).
- alu_op=10, funct7=0000001, funct3=000 (MUL), MUL_LAT=2 → mdu_start at cycle 1, out_valid at cycle 2, operation=16, in_ready=0 on cycles 1–2.
- DIV (funct3=100), DIV_LAT=33, flush at cycle 10 → mdu_kill pulse at cycle 11, busy=0, no out_valid; new ADD accepted at cycle 11.
- DIVU completing while stall_in=1 for cycles 30–40 → out_valid=1 held in DONE from cycle 33 until stall_in falls; IDLE the following cycle.
- alu_op=10, funct3=101, funct7=0010000 → illegal=1, operation=2, no mdu_start; alu_op=01, funct3=010 → illegal=1.
- Assert reset mid-BUSY at cycle 5 → all outputs 0 immediately (asynchronous), FSM IDLE after release.
